tcp_sched_flag_table: RTL

- Per-flow scheduler state table for the TCP engine.
- Consumes scheduler commands (flowid plus set/clear/nop for the retransmit-pending, ack-pending and data-pending flags, each with a timestamp) from the RX/timer/app-side producers.
- Holds one flag+timestamp triple per flow.
- A round-robin scanner emits the full flag snapshot of every flow with any flag set to the send engine, which builds packets and issues CLEAR commands back.

---
 rtl/tcp_sched_flag_table_if.sv | 27 ++
 rtl/tcp_sched_flag_table.sv | 127 ++++++++++++
 2 files changed

// File: rtl/tcp_sched_flag_table_if.sv
// rtl/tcp_sched_flag_table_if.sv - command and schedule stream bundle for the flow flag table
interface tcp_sched_flag_table_if #(
    parameter int FLOWID_W    = 3,
    parameter int TIMESTAMP_W = 64
);
    localparam int CMD_W  = FLOWID_W + 3 * (2 + TIMESTAMP_W);
    localparam int DATA_W = FLOWID_W + 3 * (1 + TIMESTAMP_W);

    logic              cmd_val;
    logic              cmd_rdy;
    logic [CMD_W-1:0]  cmd_data;
    logic              sched_val;
    logic              sched_rdy;
    logic [DATA_W-1:0] sched_data;

    // Producer/consumer side: drives commands, accepts scheduled flows
    modport master (
        output cmd_val, cmd_data, sched_rdy,
        input  cmd_rdy, sched_val, sched_data
    );

    // Table side
    modport slave (
        input  cmd_val, cmd_data, sched_rdy,
        output cmd_rdy, sched_val, sched_data
    );
endinterface

// File: rtl/tcp_sched_flag_table.sv
// rtl/tcp_sched_flag_table.sv - per-flow retransmit/ack/data flag table with round-robin scanner
module tcp_sched_flag_table #(
    parameter int FLOWID_W    = 3,
    parameter int TIMESTAMP_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tcp_sched_flag_table_if.slave  bus
);
    localparam int NUM_FLOWS  = 2 ** FLOWID_W;
    localparam int SUB_CMD_W  = 2 + TIMESTAMP_W;
    localparam int SUB_DATA_W = 1 + TIMESTAMP_W;
    localparam int CMD_W      = FLOWID_W + 3 * SUB_CMD_W;
    localparam int DATA_W     = FLOWID_W + 3 * SUB_DATA_W;

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_CLR = 2'd1;

    typedef enum logic {ST_SCAN, ST_OUT} state_t;

    // Sub-field index 0 = data, 1 = ack, 2 = rt (LSB upwards in the packed layout)
    logic [2:0]             flag_q [NUM_FLOWS];
    logic [TIMESTAMP_W-1:0] ts_q   [NUM_FLOWS][3];

    state_t                 state;
    logic [FLOWID_W-1:0]    scan_ptr;
    logic                   sched_val_q;
    logic [DATA_W-1:0]      sched_data_q;

    logic                   cmd_fire;
    logic [FLOWID_W-1:0]    cmd_flow;
    logic [1:0]             sub_op [3];
    logic [TIMESTAMP_W-1:0] sub_ts [3];
    logic [2:0]             eff_flag;
    logic [TIMESTAMP_W-1:0] eff_ts [3];
    logic [3*SUB_DATA_W-1:0] eff_data;

    // Commands are never backpressured outside reset
    assign bus.cmd_rdy    = rst_n;
    assign bus.sched_val  = sched_val_q;
    assign bus.sched_data = sched_data_q;

    assign cmd_fire = bus.cmd_val & bus.cmd_rdy;
    assign cmd_flow = bus.cmd_data[CMD_W-1 -: FLOWID_W];

    // Split the command into its three op/timestamp sub-fields
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            sub_op[k] = bus.cmd_data[k*SUB_CMD_W + TIMESTAMP_W +: 2];
            sub_ts[k] = bus.cmd_data[k*SUB_CMD_W +: TIMESTAMP_W];
        end
    end

    // Entry under the scanner, with a same-cycle command to that flow bypassed in
    always_comb begin
        eff_flag = flag_q[scan_ptr];
        for (int k = 0; k < 3; k++) begin
            eff_ts[k] = ts_q[scan_ptr][k];
        end
        if (cmd_fire && (cmd_flow == scan_ptr)) begin
            for (int k = 0; k < 3; k++) begin
                if (sub_op[k] == OP_SET) begin
                    eff_flag[k] = 1'b1;
                    eff_ts[k]   = sub_ts[k];
                end else if (sub_op[k] == OP_CLR) begin
                    eff_flag[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            eff_data[k*SUB_DATA_W +: SUB_DATA_W] = {eff_flag[k], eff_ts[k]};
        end
    end

    // Table update: each sub-field independently sets, clears or leaves its flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                flag_q[i] <= '0;
                for (int k = 0; k < 3; k++) begin
                    ts_q[i][k] <= '0;
                end
            end
        end else if (cmd_fire) begin
            for (int k = 0; k < 3; k++) begin
                case (sub_op[k])
                    OP_SET: begin
                        flag_q[cmd_flow][k] <= 1'b1;
                        ts_q[cmd_flow][k]   <= sub_ts[k];
                    end
                    OP_CLR:  flag_q[cmd_flow][k] <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Scanner: snapshot the first active flow, hold it until the send engine takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_SCAN;
            scan_ptr     <= '0;
            sched_val_q  <= 1'b0;
            sched_data_q <= '0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (|eff_flag) begin
                        sched_data_q <= {scan_ptr, eff_data};
                        sched_val_q  <= 1'b1;
                        state        <= ST_OUT;
                    end else begin
                        scan_ptr <= scan_ptr + FLOWID_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.sched_rdy) begin
                        sched_val_q <= 1'b0;
                        scan_ptr    <= scan_ptr + FLOWID_W'(1);
                        state       <= ST_SCAN;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end
endmodule
